// File: rtl/wb_regfile.sv
// Writeback stage register file: selects the writeback value, commits it
// to a 32x32 integer file, and serves bypassed read ports plus a debug port.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [3:0]      WB_control,
  input  logic [AW-1:0]   RegDst,
  input  logic [XLEN-1:0] ReadData,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] PC,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_en,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [31:0]     wb_count
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [31:0]     cnt_q;
  logic [31:0]     cnt_d;
  logic [XLEN-1:0] wb_data_d;
  logic            reg_write;
  logic            mem_to_reg;
  logic [1:0]      reg_src;
  logic            wb_en_d;

  assign reg_write  = WB_control[3];
  assign mem_to_reg = WB_control[2];
  assign reg_src    = WB_control[1:0];

  // Writeback value select; load data overrides the RegSrc field.
  always_comb begin
    wb_data_d = ALUResult;
    unique case (1'b1)
      mem_to_reg:
        wb_data_d = ReadData;
      !mem_to_reg && reg_src == 2'b01:
        wb_data_d = PC + XLEN'(4);
      !mem_to_reg && reg_src == 2'b11:
        wb_data_d = PC;
      default:
        wb_data_d = ALUResult;
    endcase
  end

  assign wb_en_d  = reg_write && (RegDst != '0) && RESET;
  assign wb_data  = wb_data_d;
  assign wb_en    = wb_en_d;
  assign cnt_d    = wb_en_d ? cnt_q + 32'd1 : cnt_q;
  assign wb_count = cnt_q;

  // Register array commit; entry 0 is never written so it stays zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en_d) begin
      regs_q[RegDst] <= wb_data_d;
    end
  end

  // Committed-write event counter, free-running wrap.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read ports: zero in reset and for x0, bypass the in-flight write.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    dbg_data = '0;
    if (RESET) begin
      if (rs1_addr != '0) begin
        rs1_data = (wb_en_d && rs1_addr == RegDst)
                 ? wb_data_d : regs_q[rs1_addr];
      end
      if (rs2_addr != '0) begin
        rs2_data = (wb_en_d && rs2_addr == RegDst)
                 ? wb_data_d : regs_q[rs2_addr];
      end
      if (dbg_addr != '0) begin
        dbg_data = regs_q[dbg_addr];
      end
    end
  end

endmodule
